// File: rtl/poly_square_synth.sv
// poly_square_synth: N-voice polyphonic square-wave synthesiser.
// Parsed MIDI channel messages drive a small voice allocator; each active
// voice is a square oscillator. Voices are mixed by velocity and a
// first-order sigma-delta modulator produces the 1-bit buzz output.
module poly_square_synth #(
  parameter int VOICES   = 4,
  parameter int CLK_HZ   = 12000000,
  parameter bit OMNI     = 1'b1,
  parameter int MIDI_CH  = 0,
  parameter int PERIOD_W = 21
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic              msg_valid,
  input  logic [7:0]        msg_status,
  input  logic [7:0]        msg_data1,
  input  logic [7:0]        msg_data2,
  output logic              buzz,
  output logic [VOICES-1:0] voice_active,
  output logic              steal
);

  localparam int PTR_W = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int SUM_W = 7 + $clog2(VOICES);
  localparam int ACC_W = SUM_W + 1;
  localparam logic [ACC_W-1:0] FS = ACC_W'(127 * VOICES);

  // Decoded message operation
  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_ON   = 2'd1;
  localparam logic [1:0] OP_OFF  = 2'd2;
  localparam logic [1:0] OP_ALL  = 2'd3;

  // Rescale a 12 MHz octave-0 period to the real clock, rounding to nearest.
  function automatic logic [PERIOD_W-1:0] scale_period(input longint unsigned p12);
    longint unsigned clk_l;
    longint unsigned scaled;
    clk_l  = {32'd0, 32'(CLK_HZ)};
    scaled = (p12 * clk_l + 64'd6000000) / 64'd12000000;
    return PERIOD_W'(scaled);
  endfunction

  // Octave-0 periods (notes 0..11); higher octaves are right shifts.
  localparam logic [PERIOD_W-1:0] P0_TAB [12] = '{
    scale_period(64'd1467776), scale_period(64'd1385392),
    scale_period(64'd1307648), scale_period(64'd1234256),
    scale_period(64'd1164976), scale_period(64'd1099584),
    scale_period(64'd1037872), scale_period(64'd979632),
    scale_period(64'd924640),  scale_period(64'd872752),
    scale_period(64'd823760),  scale_period(64'd777536)
  };

  // Voice state
  logic [VOICES-1:0]   active_q, active_d;
  logic [6:0]          note_q   [VOICES];
  logic [6:0]          note_d   [VOICES];
  logic [6:0]          vel_q    [VOICES];
  logic [6:0]          vel_d    [VOICES];
  logic [PERIOD_W-1:0] period_q [VOICES];
  logic [PERIOD_W-1:0] period_d [VOICES];
  logic [PERIOD_W-1:0] phase_q  [VOICES];
  logic [PERIOD_W-1:0] phase_d  [VOICES];
  logic [PTR_W-1:0]    steal_ptr_q, steal_ptr_d;
  logic                steal_evt_q, steal_evt_d;

  // Modulator and output registers
  logic [SUM_W-1:0]    acc_q, acc_d;
  logic                buzz_q, buzz_d;
  logic [VOICES-1:0]   voice_active_q;
  logic                steal_q;

  // Decode / search / mix nets
  logic [6:0]          note_s;
  logic [6:0]          vel_s;
  logic                ch_ok_s;
  logic [1:0]          op_s;
  logic [3:0]          note_lo_s;
  logic [3:0]          oct_s;
  logic [PERIOD_W-1:0] new_period_s;
  logic [VOICES-1:0]   match_vec_s;
  logic                hit_s;
  logic [PTR_W-1:0]    hit_idx_s;
  logic                free_s;
  logic [PTR_W-1:0]    free_idx_s;
  logic [VOICES-1:0]   sq_s;
  logic [SUM_W-1:0]    sum_s;
  logic [ACC_W-1:0]    t_s;
  logic                unused_s;

  assign note_s   = msg_data1[6:0];
  assign vel_s    = msg_data2[6:0];
  assign unused_s = ^{msg_data1[7], msg_data2[7]};
  assign ch_ok_s  = OMNI || (msg_status[3:0] == 4'(MIDI_CH));

  // Classify the incoming message; anything unrecognised becomes OP_NONE.
  always_comb begin
    op_s = OP_NONE;
    if (msg_valid && ch_ok_s) begin
      case (msg_status[7:4])
        4'h9:    op_s = (vel_s != 7'd0) ? OP_ON : OP_OFF;
        4'h8:    op_s = OP_OFF;
        4'hB:    op_s = (note_s == 7'd123) ? OP_ALL : OP_NONE;
        default: op_s = OP_NONE;
      endcase
    end else begin
      op_s = OP_NONE;
    end
  end

  // Period lookup for the incoming note: octave-0 entry shifted by octave.
  always_comb begin
    note_lo_s    = 4'(note_s % 7'd12);
    oct_s        = 4'(note_s / 7'd12);
    new_period_s = P0_TAB[note_lo_s] >> oct_s;
  end

  // Find voices holding the note and the lowest-index free voice.
  always_comb begin
    match_vec_s = '0;
    hit_s       = 1'b0;
    hit_idx_s   = PTR_W'(0);
    free_s      = 1'b0;
    free_idx_s  = PTR_W'(0);
    for (int i = VOICES - 1; i >= 0; i--) begin
      match_vec_s[i] = active_q[i] && (note_q[i] == note_s);
      hit_s          = hit_s | match_vec_s[i];
      hit_idx_s      = match_vec_s[i] ? PTR_W'(i) : hit_idx_s;
      free_s         = free_s | ~active_q[i];
      free_idx_s     = (~active_q[i]) ? PTR_W'(i) : free_idx_s;
    end
  end

  // Next voice state: free-running oscillators, then the message overrides.
  always_comb begin
    active_d    = active_q;
    steal_ptr_d = steal_ptr_q;
    steal_evt_d = 1'b0;
    for (int v = 0; v < VOICES; v++) begin
      note_d[v]   = note_q[v];
      vel_d[v]    = vel_q[v];
      period_d[v] = period_q[v];
      if (active_q[v]) begin
        phase_d[v] = (phase_q[v] == period_q[v] - PERIOD_W'(1)) ?
                     PERIOD_W'(0) : phase_q[v] + PERIOD_W'(1);
      end else begin
        phase_d[v] = PERIOD_W'(0);
      end
    end
    case (op_s)
      OP_ON: begin
        if (hit_s) begin
          // Retrigger the voice already playing this note
          vel_d[hit_idx_s]   = vel_s;
          phase_d[hit_idx_s] = PERIOD_W'(0);
        end else if (free_s) begin
          active_d[free_idx_s] = 1'b1;
          note_d[free_idx_s]   = note_s;
          vel_d[free_idx_s]    = vel_s;
          period_d[free_idx_s] = new_period_s;
          phase_d[free_idx_s]  = PERIOD_W'(0);
        end else begin
          // All voices busy: round-robin steal
          note_d[steal_ptr_q]   = note_s;
          vel_d[steal_ptr_q]    = vel_s;
          period_d[steal_ptr_q] = new_period_s;
          phase_d[steal_ptr_q]  = PERIOD_W'(0);
          steal_evt_d           = 1'b1;
          steal_ptr_d = (steal_ptr_q == PTR_W'(VOICES - 1)) ?
                        PTR_W'(0) : steal_ptr_q + PTR_W'(1);
        end
      end
      OP_OFF: begin
        active_d = active_q & ~match_vec_s;
        for (int v = 0; v < VOICES; v++) begin
          phase_d[v] = match_vec_s[v] ? PERIOD_W'(0) : phase_d[v];
        end
      end
      OP_ALL: begin
        active_d = '0;
        for (int v = 0; v < VOICES; v++) begin
          phase_d[v] = PERIOD_W'(0);
        end
      end
      default: begin
        active_d = active_q;
      end
    endcase
  end

  // Square outputs and velocity-weighted mix of all sounding voices.
  always_comb begin
    sum_s = SUM_W'(0);
    for (int v = 0; v < VOICES; v++) begin
      sq_s[v] = active_q[v] && (phase_q[v] < (period_q[v] >> 1));
      sum_s   = sum_s + (sq_s[v] ? SUM_W'(vel_q[v]) : SUM_W'(0));
    end
  end

  // First-order sigma-delta: carry out of the accumulator is the output bit.
  always_comb begin
    t_s = ACC_W'(acc_q) + ACC_W'(sum_s);
    if (t_s >= FS) begin
      buzz_d = 1'b1;
      acc_d  = SUM_W'(t_s - FS);
    end else begin
      buzz_d = 1'b0;
      acc_d  = SUM_W'(t_s);
    end
  end

  // Voice state registers; reset takes precedence over any message.
  always_ff @(posedge clk) begin
    if (resetq) begin
      active_q    <= '0;
      steal_ptr_q <= PTR_W'(0);
      steal_evt_q <= 1'b0;
      for (int v = 0; v < VOICES; v++) begin
        note_q[v]   <= 7'd0;
        vel_q[v]    <= 7'd0;
        period_q[v] <= PERIOD_W'(0);
        phase_q[v]  <= PERIOD_W'(0);
      end
    end else begin
      active_q    <= active_d;
      steal_ptr_q <= steal_ptr_d;
      steal_evt_q <= steal_evt_d;
      note_q      <= note_d;
      vel_q       <= vel_d;
      period_q    <= period_d;
      phase_q     <= phase_d;
    end
  end

  // Modulator accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (resetq) begin
      acc_q          <= SUM_W'(0);
      buzz_q         <= 1'b0;
      voice_active_q <= '0;
      steal_q        <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      buzz_q         <= buzz_d;
      voice_active_q <= active_q;
      steal_q        <= steal_evt_q;
    end
  end

  assign buzz         = buzz_q;
  assign voice_active = voice_active_q;
  assign steal        = steal_q;

endmodule

// File: tb/tb_poly_square_synth.sv
// Self-checking bench for poly_square_synth: an omni instance and a
// channel-2-only instance share one stimulus stream and are compared every
// cycle against a note/timestamp level reference model.
module tb_poly_square_synth;

  localparam int V  = 4;
  localparam int FS = 127 * V;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetq;
  logic         msg_valid;
  logic [7:0]   st, d1, d2;
  logic         buzz0, buzz1, steal0, steal1;
  logic [V-1:0] va0, va1;

  poly_square_synth #(.VOICES(V), .OMNI(1'b1), .MIDI_CH(0)) dut0 (
    .clk(clk), .resetq(resetq), .msg_valid(msg_valid), .msg_status(st),
    .msg_data1(d1), .msg_data2(d2), .buzz(buzz0), .voice_active(va0),
    .steal(steal0));

  poly_square_synth #(.VOICES(V), .OMNI(1'b0), .MIDI_CH(2)) dut1 (
    .clk(clk), .resetq(resetq), .msg_valid(msg_valid), .msg_status(st),
    .msg_data1(d1), .msg_data2(d2), .buzz(buzz1), .voice_active(va1),
    .steal(steal1));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model, index 0 = omni instance, 1 = channel-2 instance.
  // A voice started at edge s has phase (u - s) mod period after edge u.
  int     m_act   [2][V];
  int     m_note  [2][V];
  int     m_vel   [2][V];
  int     m_per   [2][V];
  longint m_start [2][V];
  int     m_ptr   [2];
  int     m_acc   [2];
  int     m_pend  [2];
  int     exp_va  [2];
  int     exp_buzz[2];
  int     exp_steal[2];
  longint now = 0;

  int buzz_ones = 0;
  int steal_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  function automatic int period_of(input int n);
    int p0 [12];
    p0 = '{1467776, 1385392, 1307648, 1234256, 1164976, 1099584,
           1037872, 979632, 924640, 872752, 823760, 777536};
    return p0[n % 12] >> (n / 12);
  endfunction

  task automatic note_on(input int d, input int n, input int vel);
    bit done;
    int v;
    done = 1'b0;
    for (int i = 0; i < V; i++) begin
      if (!done && m_act[d][i] != 0 && m_note[d][i] == n) begin
        m_vel[d][i] = vel; m_start[d][i] = now + 1; done = 1'b1;
      end
    end
    for (int i = 0; i < V; i++) begin
      if (!done && m_act[d][i] == 0) begin
        m_act[d][i] = 1; m_note[d][i] = n; m_vel[d][i] = vel;
        m_per[d][i] = period_of(n); m_start[d][i] = now + 1; done = 1'b1;
      end
    end
    if (!done) begin
      v = m_ptr[d];
      m_note[d][v] = n; m_vel[d][v] = vel; m_per[d][v] = period_of(n);
      m_start[d][v] = now + 1; m_pend[d] = 1;
      m_ptr[d] = (m_ptr[d] + 1) % V;
    end
  endtask

  task automatic apply_msg(input int d);
    int hi, n, vel;
    hi  = int'(st[7:4]);
    n   = int'(d1[6:0]);
    vel = int'(d2[6:0]);
    if (d == 0 || st[3:0] == 4'd2) begin
      if (hi == 9 && vel > 0) note_on(d, n, vel);
      else if (hi == 9 || hi == 8) begin
        for (int i = 0; i < V; i++)
          if (m_act[d][i] != 0 && m_note[d][i] == n) m_act[d][i] = 0;
      end else if (hi == 11 && n == 123) begin
        for (int i = 0; i < V; i++) m_act[d][i] = 0;
      end
    end
  endtask

  task automatic model_step();
    int sum, t, nva;
    longint ph;
    for (int d = 0; d < 2; d++) begin
      sum = 0; nva = 0;
      for (int v = 0; v < V; v++) begin
        if (m_act[d][v] != 0) begin
          ph = (now - m_start[d][v]) % longint'(m_per[d][v]);
          if (ph < longint'(m_per[d][v] / 2)) sum += m_vel[d][v];
          nva |= (1 << v);
        end
      end
      t = m_acc[d] + sum;
      if (resetq) begin
        for (int v = 0; v < V; v++) m_act[d][v] = 0;
        m_acc[d] = 0; m_ptr[d] = 0; m_pend[d] = 0;
        exp_buzz[d] = 0; exp_va[d] = 0; exp_steal[d] = 0;
      end else begin
        exp_buzz[d]  = (t >= FS) ? 1 : 0;
        m_acc[d]     = (t >= FS) ? t - FS : t;
        exp_va[d]    = nva;
        exp_steal[d] = m_pend[d];
        m_pend[d]    = 0;
        if (msg_valid) apply_msg(d);
      end
    end
    now++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_val("va0",    32'(va0),    32'(exp_va[0]));
    check_val("va1",    32'(va1),    32'(exp_va[1]));
    check_val("buzz0",  32'(buzz0),  32'(exp_buzz[0]));
    check_val("buzz1",  32'(buzz1),  32'(exp_buzz[1]));
    check_val("steal0", 32'(steal0), 32'(exp_steal[0]));
    check_val("steal1", 32'(steal1), 32'(exp_steal[1]));
    buzz_ones += int'(buzz0);
    steal_cnt += int'(steal0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b);
    st = s; d1 = a; d2 = b; msg_valid = 1'b1;
    tick();
    msg_valid = 1'b0;
  endtask

  task automatic do_reset();
    resetq = 1'b1;
    idle(3);
    resetq = 1'b0;
  endtask

  int r, ch;

  initial begin
    resetq = 1'b1; msg_valid = 1'b0; st = 8'd0; d1 = 8'd0; d2 = 8'd0;
    idle(3);
    resetq = 1'b0;
    check_val("rst_va", 32'(va0), 32'd0);

    // Single note 69: two-cycle visibility and 25% duty over a high half
    send(8'h90, 8'd69, 8'd127);
    check_val("t1_va_lat0", 32'(va0), 32'd0);
    buzz_ones = 0;
    tick();
    check_val("t1_va_lat1", 32'(va0), 32'd1);
    buzz_ones = int'(buzz0);
    idle(13635);
    check_val("t1_duty", 32'((buzz_ones >= 3408) && (buzz_ones <= 3410)), 32'd1);
    idle(300);

    // Four voices then two steals
    do_reset();
    steal_cnt = 0;
    send(8'h92, 8'd60, 8'd100); idle(3);
    send(8'h92, 8'd64, 8'd100); idle(3);
    send(8'h92, 8'd67, 8'd100); idle(3);
    send(8'h92, 8'd72, 8'd100); idle(3);
    send(8'h92, 8'd76, 8'd100); idle(5);
    send(8'h92, 8'd79, 8'd100); idle(2000);
    check_val("t2_steals", 32'(steal_cnt), 32'd2);
    check_val("t2_va", 32'(va0), 32'hF);

    // Note-off by vel 0 and by 0x8n; buzz then silent
    do_reset();
    send(8'h92, 8'd60, 8'd100); idle(2);
    send(8'h92, 8'd64, 8'd100); idle(200);
    send(8'h92, 8'd60, 8'd0); idle(2);
    check_val("t3_va_a", 32'(va0), 32'h2);
    send(8'h82, 8'd64, 8'd55); idle(1);
    buzz_ones = 0;
    idle(50);
    check_val("t3_va_b", 32'(va0), 32'h0);
    check_val("t3_silent", 32'(buzz_ones), 32'd0);

    // Channel filter
    do_reset();
    send(8'h93, 8'd60, 8'd100); idle(2);
    check_val("t4_ign", 32'(va1), 32'd0);
    send(8'h92, 8'd60, 8'd100); idle(2);
    check_val("t4_acc", 32'(va1), 32'd1);

    // All-notes-off, then reset colliding with a note-on
    send(8'h92, 8'd64, 8'd90); send(8'h92, 8'd67, 8'd80); send(8'h92, 8'd71, 8'd70);
    idle(300);
    send(8'hB2, 8'd121, 8'd0); idle(2);
    check_val("t5_cc_other", 32'(va1), 32'hF);
    send(8'hB2, 8'd123, 8'd0); idle(2);
    check_val("t5_alloff", 32'(va1), 32'h0);
    send(8'h92, 8'd60, 8'd100); idle(50);
    resetq = 1'b1; st = 8'h92; d1 = 8'd62; d2 = 8'd100; msg_valid = 1'b1;
    tick();
    msg_valid = 1'b0; resetq = 1'b0;
    idle(3);
    check_val("t5_rst_msg", 32'(va0), 32'd0);

    // Retrigger of a held note
    send(8'h92, 8'd60, 8'd40); idle(10000);
    send(8'h92, 8'd60, 8'd120); idle(3000);
    check_val("t6_va", 32'(va0), 32'd1);

    // Randomised traffic over a small note pool
    for (int k = 0; k < 400; k++) begin
      r  = $urandom_range(0, 9);
      ch = $urandom_range(0, 3);
      d1 = 8'({$urandom_range(0, 1), 7'(96 + $urandom_range(0, 11))});
      d2 = 8'($urandom_range(0, 255));
      case (r)
        0, 1, 2, 3, 4: st = 8'h90 | 8'(ch);
        5, 6:          st = 8'h80 | 8'(ch);
        7:             st = 8'hB0 | 8'(ch);
        8:             st = 8'($urandom_range(10, 14) << 4) | 8'(ch);
        default: begin st = 8'hB0 | 8'(ch); d1 = 8'd123; end
      endcase
      if (r < 2) d2[6:0] = ($urandom_range(0, 7) == 0) ? 7'd0 : d2[6:0];
      resetq = ($urandom_range(0, 99) == 0);
      send(st, d1, d2);
      resetq = 1'b0;
      idle($urandom_range(0, 60));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
